// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter that sequences single accesses onto a shared
// single-port memory; port 0 is instruction side, port 1 is data side.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_enable,
    output logic              mem_R_W,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_D_In,
    input  logic [DATA_W-1:0] mem_D_Out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic              grant, grant_nxt;
    logic              last_grant, last_grant_nxt;
    logic              ack0_nxt, ack1_nxt, en_nxt, rw_nxt, busy_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt, rdata0_nxt, rdata1_nxt;

    // Next-state, arbitration and next values of every registered output.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        en_nxt         = 1'b0;
        rw_nxt         = 1'b1;
        busy_nxt       = busy;
        addr_nxt       = mem_Address;
        din_nxt        = mem_D_In;
        rdata0_nxt     = rdata0;
        rdata1_nxt     = rdata1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to the port that did not win last time.
                    if (req0 && req1) grant_nxt = ~last_grant;
                    else              grant_nxt = req1;
                    state_nxt = ACCESS;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    rw_nxt    = grant_nxt ? ~we1 : ~we0;
                    addr_nxt  = grant_nxt ? addr1 : addr0;
                    din_nxt   = grant_nxt ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                state_nxt      = DONE;
                last_grant_nxt = grant;
                ack0_nxt       = ~grant;
                ack1_nxt       = grant;
                if (mem_R_W) begin
                    if (grant) rdata1_nxt = mem_D_Out;
                    else       rdata0_nxt = mem_D_Out;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mem_enable  <= 1'b0;
            mem_R_W     <= 1'b1;
            busy        <= 1'b0;
            mem_Address <= '0;
            mem_D_In    <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            last_grant  <= last_grant_nxt;
            ack0        <= ack0_nxt;
            ack1        <= ack1_nxt;
            mem_enable  <= en_nxt;
            mem_R_W     <= rw_nxt;
            busy        <= busy_nxt;
            mem_Address <= addr_nxt;
            mem_D_In    <= din_nxt;
            rdata0      <= rdata0_nxt;
            rdata1      <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory
// and hand-computed expected values.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_enable, mem_R_W, busy;
    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_D_In, mem_D_Out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] m_rd0, m_rd1;
    logic              prev_en = 1'b0;
    logic [DATA_W-1:0] vals [7];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_enable(mem_enable), .mem_R_W(mem_R_W),
        .mem_Address(mem_Address), .mem_D_In(mem_D_In),
        .mem_D_Out(mem_D_Out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the enabled edge.
    assign mem_D_Out = mem[mem_Address[7:0]];
    always @(posedge clk) begin
        if (mem_enable && !mem_R_W) mem[mem_Address[7:0]] <= mem_D_In;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("en_single", 64'(prev_en & mem_enable), 64'd0);
            check("ack_overlap", 64'(ack0 & ack1), 64'd0);
        end
        prev_en = mem_enable;
    end

    task automatic xact(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd);
        @(negedge clk);
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        @(negedge clk);
        check("acc_en", 64'(mem_enable), 64'd1);
        check("acc_rw", 64'(mem_R_W), 64'(!we));
        check("acc_addr", 64'(mem_Address), 64'(addr));
        if (we) check("acc_din", 64'(mem_D_In), 64'(wdata));
        check("acc_busy", 64'(busy), 64'd1);
        check("acc_noack", 64'({ack1, ack0}), 64'd0);
        @(negedge clk);
        if (!we) begin
            if (port) m_rd1 = exp_rd;
            else      m_rd0 = exp_rd;
        end
        check("done_ack", 64'({ack1, ack0}), port ? 64'd2 : 64'd1);
        check("done_en", 64'(mem_enable), 64'd0);
        check("done_rw", 64'(mem_R_W), 64'd1);
        check("done_busy", 64'(busy), 64'd1);
        check("rdata0", 64'(rdata0), 64'(m_rd0));
        check("rdata1", 64'(rdata1), 64'(m_rd1));
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_rd0 = '0;
        m_rd1 = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        vals = '{32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 32'h0000_00DD,
                 32'h0000_00EE, 32'h0000_00FF, 32'h0000_FFFF};
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        m_rd0 = '0; m_rd1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 64'({ack1, ack0}), 64'd0);
        check("rst_en", 64'(mem_enable), 64'd0);
        check("rst_rw", 64'(mem_R_W), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mem_Address), 64'd0);
        check("rst_din", 64'(mem_D_In), 64'd0);
        check("rst_rdata", 64'({rdata1, rdata0}), 64'd0);
        reset = 1'b0;

        // Port 0 write
        xact(1'b0, 1'b1, 16'h0000, 32'h0000_AAAA, '0);
        check("mem0", 64'(mem[0]), 64'h0000_AAAA);

        // Port 1 writes addr 1..7, port 0 reads addr 3
        for (int i = 0; i < 7; i++) xact(1'b1, 1'b1, 16'(i + 1), vals[i], '0);
        xact(1'b0, 1'b0, 16'h0003, '0, 32'h0000_00CC);
        for (int i = 0; i < 7; i++) check($sformatf("mem%0d", i + 1), 64'(mem[i + 1]), 64'(vals[i]));

        // Fresh reset, then simultaneous requests alternate starting with port 0
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("rr_ack0_%0d", k), 64'(ack0), 64'((k == 2) || (k == 8)));
            check($sformatf("rr_ack1_%0d", k), 64'(ack1), 64'((k == 5) || (k == 11)));
            if (k == 2) check("rr_rdata0", 64'(rdata0), 64'h0000_00CC);
            if (k == 5) check("rr_rdata1", 64'(rdata1), 64'h0000_00EE);
        end
        req0 = 1'b0; req1 = 1'b0;
        m_rd0 = 32'h0000_00CC;
        m_rd1 = 32'h0000_00EE;

        // Reset during ACCESS of a read
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0004;
        @(negedge clk);
        check("rsta_en", 64'(mem_enable), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rsta_ack", 64'({ack1, ack0}), 64'd0);
        check("rsta_busy", 64'(busy), 64'd0);
        check("rsta_en0", 64'(mem_enable), 64'd0);
        check("rsta_rw", 64'(mem_R_W), 64'd1);
        check("rsta_rdata0", 64'(rdata0), 64'd0);
        reset = 1'b0; req0 = 1'b0;
        m_rd0 = '0; m_rd1 = '0;
        @(negedge clk);
        check("rsta_idle_ack", 64'({ack1, ack0}), 64'd0);
        check("rsta_idle_busy", 64'(busy), 64'd0);
        xact(1'b0, 1'b0, 16'h0004, '0, 32'h0000_00DD);

        // req1 dropped after grant
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0007;
        @(negedge clk);
        check("drop_en", 64'(mem_enable), 64'd1);
        req1 = 1'b0;
        @(negedge clk);
        check("drop_ack", 64'({ack1, ack0}), 64'd2);
        check("drop_rdata1", 64'(rdata1), 64'h0000_FFFF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drop_idle_ack", 64'({ack1, ack0}), 64'd0);
            check("drop_idle_busy", 64'(busy), 64'd0);
            check("drop_idle_en", 64'(mem_enable), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
